// File: rtl/vga_fb_pkg.sv
// rtl/vga_fb_pkg.sv - shared slot/tag types and sizes for the framebuffer arbiter
package vga_fb_pkg;

  localparam int FB_AW   = 16;
  localparam int FB_DW   = 8;
  localparam int RD_PIPE = 3;

  typedef enum logic [2:0] {IDLE, DISP, HWR, HRD, CLR} slot_t;
  typedef enum logic [1:0] {TAG_NONE, TAG_DISP, TAG_HRD} tag_t;

  function automatic tag_t slot_to_tag(input slot_t s);
    case (s)
      DISP:    return TAG_DISP;
      HRD:     return TAG_HRD;
      default: return TAG_NONE;
    endcase
  endfunction

endpackage

// File: rtl/fb_clear_engine.sv
// rtl/fb_clear_engine.sv - framebuffer fill engine: colour latch, address counter, busy/done
// Instantiated by vga_fb_arbiter only when FB_CLEAR_EN is defined.
module fb_clear_engine #(
  parameter int AW = 16,
  parameter int DW = 8
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic          i_start,
  input  logic [DW-1:0] i_color,
  input  logic          i_adv,
  output logic          o_busy,
  output logic          o_done,
  output logic [AW-1:0] o_addr,
  output logic [DW-1:0] o_color
);

  logic          r_busy;
  logic [AW-1:0] r_cnt;
  logic [DW-1:0] r_color;
  logic          w_last;

  assign w_last = &r_cnt;

  // start is only honoured while idle; the counter wraps back to 0 after the last write
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_busy  <= 1'b0;
      r_cnt   <= '0;
      r_color <= '0;
    end else if (!r_busy) begin
      if (i_start) begin
        r_busy  <= 1'b1;
        r_cnt   <= '0;
        r_color <= i_color;
      end
    end else if (i_adv) begin
      r_cnt <= r_cnt + 1'b1;
      if (w_last) r_busy <= 1'b0;
    end
  end

  assign o_busy  = r_busy;
  assign o_done  = r_busy & i_adv & w_last;
  assign o_addr  = r_cnt;
  assign o_color = r_color;

endmodule

// File: rtl/vga_fb_arbiter.sv
// rtl/vga_fb_arbiter.sv - single-port framebuffer RAM arbiter: display > clear > host
// Optional clear engine built only when FB_CLEAR_EN is defined.
module vga_fb_arbiter
  import vga_fb_pkg::*;
#(
  parameter int AW     = FB_AW,
  parameter int DW     = FB_DW,
  parameter int RD_LAT = 1
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic          pix_ce,
  input  logic          disp_req,
  input  logic [AW-1:0] disp_addr,
  output logic          disp_vld,
  output logic [DW-1:0] disp_data,
  input  logic          host_valid,
  output logic          host_ready,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_rvalid,
  output logic [DW-1:0] host_rdata,
  input  logic          clr_start,
  input  logic [DW-1:0] clr_color,
  output logic          clr_busy,
  output logic          clr_done,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);

  slot_t         r_slot;
  slot_t         w_slot_nxt;
  tag_t          r_tag [RD_LAT];
  logic          w_disp_hit;
  logic [AW-1:0] w_clr_addr;
  logic [DW-1:0] w_clr_color;

  assign w_disp_hit = pix_ce & disp_req;
  assign host_ready = RSTN & ~w_disp_hit & ~clr_busy;

`ifdef FB_CLEAR_EN
  logic w_clr_adv;
  assign w_clr_adv = (w_slot_nxt == CLR);

  fb_clear_engine #(.AW(AW), .DW(DW)) u_clear (
    .CLK     (CLK),
    .RSTN    (RSTN),
    .i_start (clr_start),
    .i_color (clr_color),
    .i_adv   (w_clr_adv),
    .o_busy  (clr_busy),
    .o_done  (clr_done),
    .o_addr  (w_clr_addr),
    .o_color (w_clr_color)
  );
`else
  logic w_unused;
  assign clr_busy    = 1'b0;
  assign clr_done    = 1'b0;
  assign w_clr_addr  = '0;
  assign w_clr_color = '0;
  assign w_unused    = ^{clr_start, clr_color};
`endif

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) r_slot <= IDLE;
    else       r_slot <= w_slot_nxt;
  end

  always_comb begin
    w_slot_nxt = IDLE;
    if (w_disp_hit) begin
      w_slot_nxt = DISP;
    end else if (clr_busy) begin
      w_slot_nxt = CLR;
    end else if (host_valid) begin
      if (host_we) w_slot_nxt = HWR;
      else         w_slot_nxt = HRD;
    end
  end

  // IDLE slots leave the address and write data where they were
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      ram_addr  <= '0;
      ram_we    <= 1'b0;
      ram_wdata <= '0;
    end else begin
      ram_we <= 1'b0;
      case (w_slot_nxt)
        DISP: ram_addr <= disp_addr;
        HRD:  ram_addr <= host_addr;
        HWR: begin
          ram_addr  <= host_addr;
          ram_we    <= 1'b1;
          ram_wdata <= host_wdata;
        end
        CLR: begin
          ram_addr  <= w_clr_addr;
          ram_we    <= 1'b1;
          ram_wdata <= w_clr_color;
        end
        default: ;
      endcase
    end
  end

  // r_slot is the tag of the access now on ram_addr; r_tag follows it until ram_rdata is valid
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      for (int i = 0; i < RD_LAT; i++) r_tag[i] <= TAG_NONE;
      disp_vld    <= 1'b0;
      disp_data   <= '0;
      host_rvalid <= 1'b0;
      host_rdata  <= '0;
    end else begin
      r_tag[0] <= slot_to_tag(r_slot);
      for (int i = 1; i < RD_LAT; i++) r_tag[i] <= r_tag[i-1];
      disp_vld    <= (r_tag[RD_LAT-1] == TAG_DISP);
      host_rvalid <= (r_tag[RD_LAT-1] == TAG_HRD);
      if (r_tag[RD_LAT-1] == TAG_DISP) disp_data  <= ram_rdata;
      if (r_tag[RD_LAT-1] == TAG_HRD)  host_rdata <= ram_rdata;
    end
  end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb/tb_vga_fb_arbiter.sv - self-checking bench for vga_fb_arbiter
// Clear-engine scenarios run only when FB_CLEAR_EN is defined.
module tb_vga_fb_arbiter;

  localparam int AW = 16;
  localparam int DW = 8;
  localparam int NW = 1 << AW;

  logic          CLK = 1'b0;
  logic          RSTN = 1'b0;
  logic          pix_ce = 1'b0;
  logic          disp_req = 1'b0;
  logic [AW-1:0] disp_addr = '0;
  logic          disp_vld;
  logic [DW-1:0] disp_data;
  logic          host_valid = 1'b0;
  logic          host_ready;
  logic          host_we = 1'b0;
  logic [AW-1:0] host_addr = '0;
  logic [DW-1:0] host_wdata = '0;
  logic          host_rvalid;
  logic [DW-1:0] host_rdata;
  logic          clr_start = 1'b0;
  logic [DW-1:0] clr_color = '0;
  logic          clr_busy;
  logic          clr_done;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata = '0;

  vga_fb_arbiter dut (
    .CLK(CLK), .RSTN(RSTN), .pix_ce(pix_ce), .disp_req(disp_req), .disp_addr(disp_addr),
    .disp_vld(disp_vld), .disp_data(disp_data), .host_valid(host_valid), .host_ready(host_ready),
    .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata), .host_rvalid(host_rvalid),
    .host_rdata(host_rdata), .clr_start(clr_start), .clr_color(clr_color), .clr_busy(clr_busy),
    .clr_done(clr_done), .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  always #5 CLK = ~CLK;

  // synchronous single-port RAM, read-before-write
  logic [DW-1:0] mem [0:NW-1];
  always @(posedge CLK) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  bit pce_run = 1'b1;
  initial forever begin
    @(posedge CLK);
    #1;
    pix_ce = pce_run & ~pix_ce;
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, want);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct { int due; logic [DW-1:0] data; } rd_t;
  rd_t           qd[$];
  rd_t           qh[$];
  logic [DW-1:0] gold [0:NW-1];
  int            cyc = 0;
  bit            pw_v = 0;
  logic [AW-1:0] pw_a = '0;
  logic [DW-1:0] pw_d = '0;
  bit            exp_we = 0;
  logic [AW-1:0] exp_addr = '0;
  logic [DW-1:0] exp_wdata = '0;
  bit            m_busy = 0;
  bit            was_busy = 0;
  logic [AW-1:0] m_cnt = '0;
  logic [DW-1:0] m_color = '0;

  always @(posedge CLK) begin
    if (!RSTN) begin
      qd.delete();
      qh.delete();
      pw_v = 0;
      exp_we = 0;
      m_busy = 0;
      m_cnt = '0;
    end else begin
      cyc++;
      if (pw_v) gold[pw_a] = pw_d;
      pw_v = 0;
      was_busy = m_busy;
      if (pix_ce && disp_req) begin
        qd.push_back('{due: cyc + 2, data: gold[disp_addr]});
      end else if (m_busy) begin
        pw_v = 1; pw_a = m_cnt; pw_d = m_color;
        if (m_cnt == AW'(NW - 1)) m_busy = 0;
        m_cnt = m_cnt + 1'b1;
      end else if (host_valid) begin
        if (host_we) begin
          pw_v = 1; pw_a = host_addr; pw_d = host_wdata;
        end else begin
          qh.push_back('{due: cyc + 2, data: gold[host_addr]});
        end
      end
`ifdef FB_CLEAR_EN
      if (!was_busy && clr_start) begin
        m_busy = 1; m_cnt = '0; m_color = clr_color;
      end
`endif
      exp_we = pw_v; exp_addr = pw_a; exp_wdata = pw_d;
    end
  end

  // ---------------- compare process ----------------
  bit            edv, ehv, edone;
  int            dv_cnt = 0, hr_cnt = 0, we_cnt = 0, done_cnt = 0;
  int            last_dv_cyc = 0, last_hr_cyc = 0;
  logic [DW-1:0] last_dv_data = '0, last_hr_data = '0;

  always @(negedge CLK) begin
    if (!RSTN) begin
      chk("rst_disp_vld", disp_vld, 0);
      chk("rst_disp_data", disp_data, 0);
      chk("rst_host_rvalid", host_rvalid, 0);
      chk("rst_host_rdata", host_rdata, 0);
      chk("rst_host_ready", host_ready, 0);
      chk("rst_ram_we", ram_we, 0);
      chk("rst_ram_addr", ram_addr, 0);
      chk("rst_ram_wdata", ram_wdata, 0);
      chk("rst_clr_busy", clr_busy, 0);
      chk("rst_clr_done", clr_done, 0);
    end else begin
      edv = (qd.size() > 0) && (qd[0].due == cyc);
      ehv = (qh.size() > 0) && (qh[0].due == cyc);
      chk("disp_vld", disp_vld, edv);
      if (edv) begin
        chk("disp_data", disp_data, qd[0].data);
        void'(qd.pop_front());
      end
      chk("host_rvalid", host_rvalid, ehv);
      if (ehv) begin
        chk("host_rdata", host_rdata, qh[0].data);
        void'(qh.pop_front());
      end
      chk("ram_we", ram_we, exp_we);
      if (exp_we) begin
        chk("ram_addr", ram_addr, exp_addr);
        chk("ram_wdata", ram_wdata, exp_wdata);
      end
      chk("host_ready", host_ready, !(pix_ce && disp_req) && !m_busy);
      chk("clr_busy", clr_busy, m_busy);
      edone = m_busy && !(pix_ce && disp_req) && (m_cnt == AW'(NW - 1));
      chk("clr_done", clr_done, edone);
      if (disp_vld) begin dv_cnt++; last_dv_cyc = cyc; last_dv_data = disp_data; end
      if (host_rvalid) begin hr_cnt++; last_hr_cyc = cyc; last_hr_data = host_rdata; end
      if (ram_we) we_cnt++;
      if (clr_done) done_cnt++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge CLK);
      #2;
    end
  endtask

  task automatic host_xfer(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d, output int acc);
    bit got = 0;
    acc = -1;
    host_valid = 1'b1; host_we = we; host_addr = a; host_wdata = d;
    for (int n = 0; n < 64 && !got; n++) begin
      #1;
      if (host_ready) begin
        step();
        acc = cyc;
        got = 1;
      end else begin
        step();
      end
    end
    host_valid = 1'b0;
    total++;
    if (!got) begin
      bad++;
      $display("FAIL host_accept: addr %h not accepted within 64 cycles", a);
    end
  endtask

  int k, n0, h0, w0, d0, fa, nbad;

  initial begin
    for (int i = 0; i < NW; i++) begin
      logic [15:0] a;
      a = 16'(i);
      mem[i]  = a[7:0] ^ a[15:8];
      gold[i] = a[7:0] ^ a[15:8];
    end

    // 1: reset mid-traffic, then a single fetch of 0x0100
    step(3);
    RSTN = 1'b1;
    disp_req = 1'b1; host_valid = 1'b1; host_we = 1'b0; host_addr = 16'h0042;
    for (int i = 0; i < 12; i++) begin
      disp_addr = 16'h0200 + 16'(i);
      step();
    end
    RSTN = 1'b0;
    #1;
    chk("t1_rst_async_ram_addr", ram_addr, 0);
    step(3);
    disp_req = 1'b0; host_valid = 1'b0;
    RSTN = 1'b1;
    step(2);
    n0 = dv_cnt;
    if (!pix_ce) step();
    disp_addr = 16'h0100; disp_req = 1'b1;
    step();
    k = cyc;
    disp_req = 1'b0;
    step(4);
    chk("t1_dv_count", dv_cnt - n0, 1);
    chk("t1_latency", last_dv_cyc - k + 1, 3);
    chk("t1_data", last_dv_data, 8'h01);

    // 2: continuous display with a held host read
    n0 = dv_cnt; h0 = hr_cnt;
    disp_req = 1'b1; host_valid = 1'b1; host_we = 1'b0; host_addr = 16'h0300;
    for (int i = 0; i < 40; i++) begin
      disp_addr = 16'h1000 + 16'(i);
      step();
    end
    disp_req = 1'b0; host_valid = 1'b0;
    step(4);
    chk("t2_disp_strobes", dv_cnt - n0, 20);
    chk("t2_host_strobes", hr_cnt - h0, 20);
    chk("t2_host_data", last_hr_data, 8'h03);

    // 3: host write then read back
    h0 = hr_cnt;
    host_xfer(1'b1, 16'h1234, 8'hE3, k);
    host_xfer(1'b0, 16'h1234, 8'h00, k);
    step(4);
    chk("t3_hr_count", hr_cnt - h0, 1);
    chk("t3_latency", last_hr_cyc - k + 1, 3);
    chk("t3_data", last_hr_data, 8'hE3);

    // 4: disp_req without pix_ce is ignored; host owns every slot
    pce_run = 1'b0;
    step(2);
    disp_req = 1'b1; disp_addr = 16'h0100;
    n0 = dv_cnt; h0 = hr_cnt; w0 = we_cnt;
    host_xfer(1'b1, 16'h2000, 8'h11, k);
    host_xfer(1'b1, 16'h2001, 8'h22, k);
`ifndef FB_CLEAR_EN
    clr_color = 8'hFF; clr_start = 1'b1;
    step();
    clr_start = 1'b0;
`endif
    host_xfer(1'b0, 16'h2001, 8'h00, k);
    step(4);
    chk("t4_no_disp", dv_cnt - n0, 0);
    chk("t4_writes", we_cnt - w0, 2);
    chk("t4_hr_count", hr_cnt - h0, 1);
    chk("t4_rdata", last_hr_data, 8'h22);
    chk("t4_clr_busy", clr_busy, 0);
    disp_req = 1'b0;
    pce_run = 1'b1;
    step(2);

`ifdef FB_CLEAR_EN
    // 6: reset mid-clear, restart from address 0
    disp_req = 1'b1;
    clr_color = 8'h55; clr_start = 1'b1;
    step();
    clr_start = 1'b0;
    step(100);
    chk("t6_busy", clr_busy, 1);
    clr_color = 8'hAA; clr_start = 1'b1;
    step();
    clr_start = 1'b0;
    step(50);
    RSTN = 1'b0;
    #1;
    chk("t6_busy_rst", clr_busy, 0);
    step(2);
    RSTN = 1'b1;
    step(2);
    // 5: full clear to 0x1C under initial display traffic
    d0 = done_cnt;
    clr_color = 8'h1C; clr_start = 1'b1;
    step();
    clr_start = 1'b0;
    fa = -1;
    for (int i = 0; i < 6; i++) begin
      if (ram_we && fa < 0) fa = int'(ram_addr);
      step();
    end
    chk("t6_first_clear_addr", fa, 0);
    step(200);
    disp_req = 1'b0;
    for (int i = 0; i < 70000 && clr_busy; i++) step();
    chk("t5_busy_end", clr_busy, 0);
    chk("t5_done_once", done_cnt - d0, 1);
    step(2);
    nbad = 0;
    for (int i = 0; i < NW; i++) if (mem[i] !== 8'h1C) nbad++;
    chk("t5_mem_all_1c", nbad, 0);
    host_xfer(1'b0, 16'hBEEF, 8'h00, k);
    step(4);
    chk("t5_readback", last_hr_data, 8'h1C);
`endif

    step(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3000000;
    bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
